lms_weight_update: RTL and testbench



---
 rtl/lms_weight_update.sv | 125 ++++++++++++
 tb/tb_lms_weight_update.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lms_weight_update.sv
// Delayed-LMS adaptation stage: aligns (x, d) with the pipelined filter output,
// registers the saturated error and applies a saturating weight update.
module lms_weight_update #(
  parameter int WIDTH    = 16,
  parameter int QP       = 12,
  parameter int LEN      = 8,
  parameter int MU_SHIFT = 4,
  parameter int PIPE_LAT = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [LEN*WIDTH-1:0]   x_packed,
  input  logic [WIDTH-1:0]       d_in,
  input  logic [WIDTH-1:0]       y_in,
  input  logic                   update_en,
  output logic [LEN*WIDTH-1:0]   w_packed,
  output logic [WIDTH-1:0]       err_out,
  output logic                   err_valid
);

  localparam int VW = LEN * WIDTH;
  localparam int SH = QP + MU_SHIFT;

  function automatic logic [WIDTH-1:0] sat(input logic [2*WIDTH-1:0] v);
    logic [WIDTH:0] top;
    top = v[2*WIDTH-1:WIDTH-1];
    if ((&top) || !(|top)) return v[WIDTH-1:0];
    return v[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                        : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic logic [2*WIDTH-1:0] sx(input logic [WIDTH-1:0] a);
    return {{WIDTH{a[WIDTH-1]}}, a};
  endfunction

  logic             w_vd;
  logic [VW-1:0]    w_xd;
  logic [WIDTH-1:0] w_dd;

  generate
    if (PIPE_LAT == 0) begin : g_bypass
      assign w_vd = in_valid;
      assign w_xd = x_packed;
      assign w_dd = d_in;
    end else begin : g_dly
      logic [PIPE_LAT-1:0]            r_v;
      logic [PIPE_LAT-1:0][VW-1:0]    r_x;
      logic [PIPE_LAT-1:0][WIDTH-1:0] r_d;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_v <= '0;
          r_x <= '0;
          r_d <= '0;
        end else begin
          r_v[0] <= in_valid;
          r_x[0] <= x_packed;
          r_d[0] <= d_in;
          for (int k = 1; k < PIPE_LAT; k++) begin
            r_v[k] <= r_v[k-1];
            r_x[k] <= r_x[k-1];
            r_d[k] <= r_d[k-1];
          end
        end
      end

      assign w_vd = r_v[PIPE_LAT-1];
      assign w_xd = r_x[PIPE_LAT-1];
      assign w_dd = r_d[PIPE_LAT-1];
    end
  endgenerate

  logic [2*WIDTH-1:0] w_diff;
  logic [WIDTH-1:0]   r_err;
  logic               r_err_valid;
  logic [VW-1:0]      r_xe;
  logic [VW-1:0]      r_w;
  logic [VW-1:0]      w_wnext;

  assign w_diff = sx(w_dd) - sx(y_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err       <= '0;
      r_err_valid <= 1'b0;
      r_xe        <= '0;
    end else begin
      r_err_valid <= w_vd;
      if (w_vd) begin
        r_err <= sat(w_diff);
        r_xe  <= w_xd;
      end
    end
  end

  // Floor-shifted product then two saturation points: delta and sum.
  for (genvar i = 0; i < LEN; i++) begin : g_lane
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_shr;
    logic [2*WIDTH-1:0] w_sum;
    logic [WIDTH-1:0]   w_delta;
    logic [WIDTH-1:0]   w_cur;

    assign w_cur   = r_w[i*WIDTH +: WIDTH];
    assign w_prod  = sx(r_err) * sx(r_xe[i*WIDTH +: WIDTH]);
    assign w_shr   = $signed(w_prod) >>> SH;
    assign w_delta = sat(w_shr);
    assign w_sum   = sx(w_cur) + sx(w_delta);
    assign w_wnext[i*WIDTH +: WIDTH] = sat(w_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w <= '0;
    end else if (r_err_valid && update_en) begin
      r_w <= w_wnext;
    end
  end

  assign w_packed  = r_w;
  assign err_out   = r_err;
  assign err_valid = r_err_valid;

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update: reset, error/weight saturation,
// floor truncation, freeze/streaming and mid-stream reset.
module tb_lms_weight_update;

  localparam int W  = 16;
  localparam int L  = 8;
  localparam int PL = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [L*W-1:0] x_packed;
  logic [W-1:0]   d_in;
  logic [W-1:0]   y_in;
  logic           update_en;
  logic [L*W-1:0] w_packed;
  logic [W-1:0]   err_out;
  logic           err_valid;

  int n_chk  = 0;
  int n_pass = 0;

  lms_weight_update #(
    .WIDTH(W), .QP(12), .LEN(L), .MU_SHIFT(4), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .x_packed(x_packed), .d_in(d_in), .y_in(y_in),
    .update_en(update_en), .w_packed(w_packed),
    .err_out(err_out), .err_valid(err_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint wl(input int i);
    logic [W-1:0] v;
    v = w_packed[i*W +: W];
    return longint'($signed(v));
  endfunction

  function automatic longint el();
    return longint'($signed(err_out));
  endfunction

  function automatic logic [L*W-1:0] fill(input logic [W-1:0] v);
    return {L{v}};
  endfunction

  task automatic chk_w(input string tag, input longint e0,
                       input longint er);
    for (int i = 0; i < L; i++)
      check($sformatf("%s_w%0d", tag, i), wl(i), (i == 0) ? e0 : er);
  endtask

  // One valid pulse; returns in the cycle where its error is registered.
  task automatic pulse(input logic [L*W-1:0] x, input logic [W-1:0] d,
                       input logic [W-1:0] y);
    x_packed = x;
    d_in     = d;
    y_in     = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (PL) tick();
  endtask

  initial begin
    logic [L*W-1:0] xs;
    longint ew;

    reset     = 1'b1;
    in_valid  = 1'b1;
    x_packed  = fill(16'h1234);
    d_in      = 16'd100;
    y_in      = 16'd5;
    update_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ev", longint'(err_valid), 0);
      check("rst_err", el(), 0);
      check("rst_w0", wl(0), 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("post_rst_ev", longint'(err_valid), 0);
      check("post_rst_w7", wl(7), 0);
    end

    pulse(fill(16'd4096), 16'd4096, 16'd0);
    check("basic_ev", longint'(err_valid), 1);
    check("basic_err", el(), 4096);
    check("basic_w_old", wl(3), 0);
    tick();
    check("basic_ev_off", longint'(err_valid), 0);
    chk_w("basic", 256, 256);

    update_en = 1'b0;
    pulse(fill(16'd4096), 16'sd32767, -16'sd32768);
    check("esat_pos", el(), 32767);
    pulse(fill(16'd4096), -16'sd32768, 16'sd32767);
    check("esat_neg", el(), -32768);
    tick();
    chk_w("frozen", 256, 256);

    update_en = 1'b1;
    pulse(fill(16'd1), 16'd0, 16'd1);
    check("trunc_err", el(), -1);
    tick();
    chk_w("trunc", 255, 255);

    xs = fill(16'sd32767);
    xs[W-1:0] = -16'sd32767;
    pulse(xs, 16'sd32767, -16'sd32768);
    tick();
    chk_w("wsat1", -16129, 16638);
    pulse(xs, 16'sd32767, -16'sd32768);
    tick();
    chk_w("wsat2", -32513, 32767);
    pulse(xs, 16'sd32767, -16'sd32768);
    tick();
    chk_w("wsat3", -32768, 32767);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_w0", wl(0), 0);
    check("rst2_w5", wl(5), 0);

    x_packed = fill(16'd4096);
    d_in     = 16'd4096;
    y_in     = 16'd0;
    ew       = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid  = (c < 10);
      update_en = c[0];
      tick();
      if (c >= 6 && c <= 15 && c[0]) ew += 256;
      check($sformatf("strm_ev_c%0d", c + 1), longint'(err_valid),
            (c + 1 >= 6 && c + 1 <= 15) ? 1 : 0);
      if (c + 1 >= 6 && c + 1 <= 15)
        check($sformatf("strm_err_c%0d", c + 1), el(), 4096);
      check($sformatf("strm_w0_c%0d", c + 1), wl(0), ew);
      check($sformatf("strm_w7_c%0d", c + 1), wl(7), ew);
    end
    update_en = 1'b0;
    check("strm_final", wl(4), 1280);

    update_en = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 4; c < 10; c++) begin
      check($sformatf("mid_rst_ev_t%0d", c), longint'(err_valid), 0);
      check($sformatf("mid_rst_w_t%0d", c), wl(2), 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
